capture_readout_sequencer: RTL

Shares the single-port capture BRAM between the capture engine (write requester) and a host readout path (read requester). It streams a programmed window of samples out over a valid/ready byte stream toward the host link. Capture accesses always win. A readout read disturbed by a capture access is re-issued, so the stream never carries corrupted data.

---
 rtl/capture_readout_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/capture_readout_sequencer.sv
// rtl/capture_readout_sequencer.sv - shares the capture BRAM port with a host readout stream
module capture_readout_sequencer #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cap_en,
    input  logic              cap_we,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_din,
    input  logic              rd_start,
    input  logic              rd_abort,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] rd_count,
    output logic              rd_busy,
    output logic              rd_done,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [15:0]       conflict_cnt
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int LAT_W = 3;
    localparam logic [LAT_W-1:0]  LAT_LAST = RD_LAT[LAT_W-1:0];
    localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] remaining;
    logic [LAT_W-1:0]  lat_ctr;
    logic              rd_issue;
    logic              xfer;
    logic [15:0]       conflict_next;

    assign rd_issue = (state == ST_REQ) && !cap_en;
    assign xfer     = m_valid && m_ready;
    assign rd_busy  = (state != ST_IDLE);
    assign rd_done  = (state == ST_DONE);

    assign conflict_next = (conflict_cnt == 16'hFFFF) ? conflict_cnt : conflict_cnt + 16'd1;

    // Capture owns the port whenever it asks; the readout only fills idle cycles.
    always_comb begin
        bram_en   = rd_issue;
        bram_we   = 1'b0;
        bram_addr = rd_addr;
        bram_din  = '0;
        if (cap_en) begin
            bram_en   = 1'b1;
            bram_we   = cap_we;
            bram_addr = cap_addr;
            bram_din  = cap_din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            rd_addr      <= '0;
            remaining    <= '0;
            lat_ctr      <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            conflict_cnt <= 16'd0;
        end else if (rd_abort && (state != ST_IDLE)) begin
            state   <= ST_IDLE;
            m_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        if (rd_count != '0) begin
                            rd_addr      <= rd_base;
                            remaining    <= rd_count;
                            conflict_cnt <= 16'd0;
                            state        <= ST_REQ;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (cap_en) begin
                        conflict_cnt <= conflict_next;
                    end else begin
                        lat_ctr <= {{(LAT_W-1){1'b0}}, 1'b1};
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Any capture access while the read is in flight may corrupt it, so re-issue.
                    if (cap_en) begin
                        conflict_cnt <= conflict_next;
                        state        <= ST_REQ;
                    end else if (lat_ctr == LAT_LAST) begin
                        m_data  <= bram_dout;
                        m_valid <= 1'b1;
                        state   <= ST_PRESENT;
                    end else begin
                        lat_ctr <= lat_ctr + 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (xfer) begin
                        m_valid   <= 1'b0;
                        rd_addr   <= rd_addr + ONE;
                        remaining <= remaining - ONE;
                        state     <= (remaining > ONE) ? ST_REQ : ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
